// File: rtl/pps_mon_pkg.sv
// Shared types and helpers for the PPS miss monitor: tracking state, default
// counter width and the saturating increment used by every counter.
package pps_mon_pkg;

    localparam int DEF_CNT_W = 32;
    // Widest counter the saturating helper can serve.
    localparam int SAT_W     = 64;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } mon_state_t;

    // Returns value+1, but never steps past top (the counter's all-ones value).
    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] value,
        input logic [SAT_W-1:0] top
    );
        return (value >= top) ? top : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Brings the asynchronous PPS pin into user_clk through a 2-FF synchroniser and
// emits a registered one-cycle pulse on each synchronised rising edge.
module pps_sync_edge (
    input  logic user_clk,
    input  logic user_rst,
    input  logic pps_in,
    output logic pps_edge
);

    // [0],[1] form the synchroniser; [2] holds the previous synchronised level.
    logic [2:0] sync_reg;
    logic       edge_reg;

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            sync_reg <= '0;
            edge_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[1:0], pps_in};
            edge_reg <= sync_reg[1] & ~sync_reg[2];
        end
    end

    assign pps_edge = edge_reg;

endmodule

// File: rtl/pps_miss_monitor.sv
// Tracks the PPS edge against its expected period, counting missed and early
// edges and reporting lock, the last measured period and a clean PPS strobe.
module pps_miss_monitor
    import pps_mon_pkg::*;
#(
    parameter int unsigned PERIOD   = 256000000,
    parameter int unsigned TOL      = 256,
    parameter int unsigned MAX_MISS = 4,
    parameter int          CNT_W    = DEF_CNT_W
) (
    input  logic             user_clk,
    input  logic             user_rst,
    input  logic             pps_in,
    input  logic             clr_cnt,
    output logic             pps_strobe,
    output logic             locked,
    output logic [CNT_W-1:0] n_miss,
    output logic [CNT_W-1:0] n_early,
    output logic [CNT_W-1:0] period_last
);

    localparam int               RUN_W    = $clog2(MAX_MISS + 1);
    localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(PERIOD + TOL);
    localparam logic [CNT_W-1:0] CNT_TOL  = CNT_W'(TOL);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_MISS - 1);
    localparam logic [SAT_W-1:0] CNT_TOP  = SAT_W'({CNT_W{1'b1}});

    function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(SAT_W'(v), CNT_TOP));
    endfunction

    logic pps_edge;

    mon_state_t       state_reg,       state_next;
    logic [CNT_W-1:0] cnt_reg,         cnt_next;
    logic [CNT_W-1:0] n_miss_reg,      n_miss_next;
    logic [CNT_W-1:0] n_early_reg,     n_early_next;
    logic [CNT_W-1:0] period_last_reg, period_last_next;
    logic [RUN_W-1:0] miss_run_reg,    miss_run_next;
    logic             strobe_reg,      strobe_next;
    logic             locked_reg;

    logic is_early;
    logic at_limit;

    pps_sync_edge u_sync_edge (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .pps_in   (pps_in),
        .pps_edge (pps_edge)
    );

    assign is_early = (cnt_reg < WIN_LO);
    assign at_limit = (cnt_reg == WIN_HI);

    always_comb begin
        state_next       = state_reg;
        cnt_next         = inc_cnt(cnt_reg);
        n_miss_next      = n_miss_reg;
        n_early_next     = n_early_reg;
        period_last_next = period_last_reg;
        miss_run_next    = miss_run_reg;
        strobe_next      = 1'b0;

        case (state_reg)
            UNLOCKED: begin
                if (pps_edge) begin
                    state_next    = LOCKED;
                    cnt_next      = '0;
                    miss_run_next = '0;
                    strobe_next   = 1'b1;
                end
            end
            LOCKED: begin
                // An edge landing on the last window cycle beats the miss.
                if (pps_edge) begin
                    strobe_next      = 1'b1;
                    period_last_next = cnt_reg;
                    cnt_next         = '0;
                    miss_run_next    = '0;
                    if (is_early) begin
                        n_early_next = inc_cnt(n_early_reg);
                    end
                end else if (at_limit) begin
                    // Virtual edge: restart at TOL so the window keeps its phase.
                    n_miss_next = inc_cnt(n_miss_reg);
                    cnt_next    = CNT_TOL;
                    if (miss_run_reg == RUN_LAST) begin
                        state_next    = UNLOCKED;
                        miss_run_next = '0;
                    end else begin
                        miss_run_next = miss_run_reg + RUN_W'(1);
                    end
                end
            end
            default: begin
                state_next = UNLOCKED;
            end
        endcase

        if (clr_cnt) begin
            n_miss_next  = '0;
            n_early_next = '0;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_reg       <= UNLOCKED;
            cnt_reg         <= '0;
            n_miss_reg      <= '0;
            n_early_reg     <= '0;
            period_last_reg <= '0;
            miss_run_reg    <= '0;
            strobe_reg      <= 1'b0;
            locked_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            n_miss_reg      <= n_miss_next;
            n_early_reg     <= n_early_next;
            period_last_reg <= period_last_next;
            miss_run_reg    <= miss_run_next;
            strobe_reg      <= strobe_next;
            locked_reg      <= (state_next == LOCKED);
        end
    end

    assign pps_strobe  = strobe_reg;
    assign locked      = locked_reg;
    assign n_miss      = n_miss_reg;
    assign n_early     = n_early_reg;
    assign period_last = period_last_reg;

endmodule
